// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider.
// Produces one quotient bit per clock using a start/done handshake.
// A zero divisor short-circuits straight to the result with div_by_zero set.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // The counter must be able to hold the value WIDTH itself.
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_div;     // latched divisor D
  logic [WIDTH-1:0] r_q;       // working dividend/quotient shift register Q
  logic [WIDTH:0]   r_rem;     // partial remainder R, one bit wider than D
  logic [CntW-1:0]  r_cnt;     // steps remaining
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_last;

  // One restoring step: shift {R,Q} left, trial-subtract D, keep the result if non-negative.
  always_comb begin
    w_shift   = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_div};
    w_fits    = ~w_diff[WIDTH];
    w_rem_nxt = w_fits ? w_diff : w_shift;
    w_q_nxt   = {r_q[WIDTH-2:0], w_fits};
    w_last    = (r_cnt == CntW'(1));
  end

  // Control FSM plus datapath registers; results only change on accept (div-by-zero) or last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_div   <= divisor;
              r_q     <= dividend;
              r_rem   <= '0;
              r_cnt   <= CntW'(WIDTH);
              r_dbz   <= 1'b0;
              r_state <= ST_CALC;
            end else begin
              r_quot  <= '1;
              r_remo  <= dividend;
              r_dbz   <= 1'b1;
              r_state <= ST_FIN;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CntW'(1);
          if (w_last) begin
            // R < D here, so its top bit is always clear.
            r_quot  <= w_q_nxt;
            r_remo  <= w_rem_nxt[WIDTH-1:0];
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status decode straight from the state register.
  always_comb begin
    busy        = (r_state != ST_IDLE);
    done        = (r_state == ST_FIN);
    quotient    = r_quot;
    remainder   = r_remo;
    div_by_zero = r_dbz;
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks for seq_divider with a done-driven scoreboard.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   n_done   = 0;
  int   accepted = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: native operators, with the defined divide-by-zero result.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected entry.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.z);
        if (e.b != 0) begin
          check("invariant", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
          check("rem_lt_div", longint'(remainder < e.b), 1);
        end
      end
    end
  end

  // Leaves the caller at a falling edge with the DUT idle (or flags a timeout).
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  // Must be called at a falling edge while idle; returns 1ns into cycle 1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(e);
    accepted++;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.z = z;
    return e;
  endfunction

  // Issue one op and check busy/done cycle by cycle up to one cycle past done.
  task automatic run_timed(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e,
                           input int lat);
    wait_idle();
    issue(a, b, e);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      check($sformatf("done_c%0d", k), done, longint'(k == lat));
      check($sformatf("busy_c%0d", k), busy, longint'(k <= lat));
    end
  endtask

  initial begin
    int acc_cyc[$];
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic division with cycle-exact handshake.
    run_timed(8'd200, 8'd7, mk(8'd200, 8'd7, 8'd28, 8'd4, 1'b0), 9);
    repeat (3) @(negedge clk);
    check("hold_quot", quotient, 28);
    check("hold_rem", remainder, 4);

    // Boundaries.
    run_timed(8'd255, 8'd1, mk(8'd255, 8'd1, 8'd255, 8'd0, 1'b0), 9);
    run_timed(8'd5, 8'd9, mk(8'd5, 8'd9, 8'd0, 8'd5, 1'b0), 9);
    run_timed(8'd0, 8'd3, mk(8'd0, 8'd3, 8'd0, 8'd0, 1'b0), 9);
    run_timed(8'd255, 8'd255, mk(8'd255, 8'd255, 8'd1, 8'd0, 1'b0), 9);

    // Divide by zero: one-cycle latency.
    run_timed(8'd100, 8'd0, mk(8'd100, 8'd0, 8'd255, 8'd100, 1'b1), 1);
    check("dbz_hold", div_by_zero, 1);

    // A normal op afterwards clears div_by_zero.
    run_timed(8'd9, 8'd2, mk(8'd9, 8'd2, 8'd4, 8'd1, 1'b0), 9);

    // Start held high with operands churning every cycle.
    wait_idle();
    start = 1'b1; dividend = 8'd50; divisor = 8'd6;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) @(negedge clk);
      if (!busy) begin
        if (n == 0) sb.push_back(mk(8'd50, 8'd6, 8'd8, 8'd2, 1'b0));
        else sb.push_back(model(dividend, divisor));
        accepted++;
        acc_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      dividend = W'(50 + 37 * n);
      divisor  = W'(3 + (n % 11));
    end
    start = 1'b0;
    check("hold_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      check("period_1", acc_cyc[1] - acc_cyc[0], 10);
      check("period_2", acc_cyc[2] - acc_cyc[1], 10);
    end

    // Reset in cycle 4 of a division aborts it without a done.
    wait_idle();
    issue(8'd200, 8'd7, mk(8'd200, 8'd7, 8'd28, 8'd4, 1'b0));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_quot", quotient, 0);
    check("arst_rem", remainder, 0);
    check("arst_dbz", div_by_zero, 0);
    void'(sb.pop_back());
    accepted--;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("no_done_after_rst", done, 0);
    end
    run_timed(8'd81, 8'd9, mk(8'd81, 8'd9, 8'd9, 8'd0, 1'b0), 9);

    // Random sweep including zero divisors.
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      wait_idle();
      issue(a, b, model(a, b));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("done_count", n_done, accepted);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative unsigned restoring divider; the inverse operation to the team's combinational array multiplier.
- Produces quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Uses a start/done handshake.
- Sits beside the multiplier in the arithmetic datapath for consumers that need division.

Parameters:
- WIDTH, 8: operand, quotient and remainder width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge only while the FSM is in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured on the accepted start edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepted start edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  single-cycle pulse; results are valid in that cycle.
- quotient  output  WIDTH  unsigned quotient, registered.
- remainder  output  WIDTH  unsigned remainder, registered.
- div_by_zero  output  1  set with done when the captured divisor == 0.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; iteration counter = 0.
- Reset mid-operation aborts immediately to the reset state. No done is issued.
- States: IDLE, CALC, FIN.
- Cycle numbering: cycle 0 is the clock cycle in which start=1 is sampled in IDLE.

IDLE:
- start=1 and divisor!=0:
  - Latch divisor into D and dividend into Q.
  - Clear partial remainder R (WIDTH+1 bits).
  - Counter = WIDTH.
  - Clear div_by_zero.
  - Go to CALC.
- start=1 and divisor==0:
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
  - Go to FIN; done is high in cycle 1.
- start=0: stay in IDLE. Outputs hold their last values.

CALC (cycles 1..WIDTH), one step per cycle:
- Shift {R,Q} left by 1.
- T = R - {0,D}, computed at WIDTH+1 bits.
- If T is non-negative (MSB=0): R = T and Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
- Counter decrements.
- When the counter reaches 1 on this edge, the step completes, quotient = Q result, remainder = R[WIDTH-1:0], and the FSM goes to FIN.

FIN:
- done=1 for exactly one cycle (cycle WIDTH+1 for a normal division, cycle 1 for divide-by-zero).
- Unconditionally returns to IDLE next edge.

Latency and throughput:
- Normal division: WIDTH+1 cycles from the start cycle to done.
- Divide-by-zero: 1 cycle.
- Earliest next accepted start is the cycle after done (back-to-back period WIDTH+2 cycles).

Handshake rules:
- start is ignored while busy=1, including during FIN.
- Changing the operand inputs after the accept edge has no effect on the result.
- quotient, remainder and div_by_zero hold from done until the next accepted start. They are not cleared on re-entry to IDLE.

Arithmetic:
- Unsigned only.
- The invariant dividend = quotient*divisor + remainder holds, with remainder < divisor for divisor != 0.
- The subtractor is WIDTH+1 bits wide so that R (up to 2*divisor-1) never overflows.

Boundary conditions:
- dividend < divisor: quotient=0, remainder=dividend.
- divisor=1: quotient=dividend, remainder=0.
- dividend=0: quotient=0, remainder=0, done at the normal latency.

Test Plan:
1. WIDTH=8, dividend=200, divisor=7, start in cycle 0 -> busy high cycles 1..9; done high only in cycle 9; quotient=28, remainder=4, div_by_zero=0.
2. Boundary values:
   - 255/1 -> quotient=255, remainder=0.
   - 5/9 -> quotient=0, remainder=5.
   - 0/3 -> quotient=0, remainder=0.
   - All complete with done in cycle 9.
3. dividend=100, divisor=0 -> done and div_by_zero high in cycle 1; quotient=255, remainder=100; busy low in cycle 2.
4. start=1 held continuously with operands changed every cycle after acceptance of 50/6 -> result quotient=8, remainder=2. The next operation is accepted only in the cycle after done, with a period of 10 cycles. Check each result against the invariant.
5. Assert rst in cycle 4 of a 200/7 division -> all outputs 0 immediately (asynchronously); no done pulse; a fresh 81/9 afterwards yields quotient=9, remainder=0.
6. Randomized sweep of 2000 operand pairs, including divisor=0 -> every result matches the reference model for quotient, remainder and div_by_zero; exactly one done per accepted start.
